// File: rtl/present_round_ctrl.sv
// Iterative PRESENT-80 encryption controller.
// One shared round datapath (addRoundKey -> sLayer -> pLayer) is applied once per
// enabled clock for ROUNDS rounds, followed by a single key-whitening step that
// produces the ciphertext. The 80-bit key schedule runs on the fly alongside.
module present_round_ctrl #(
  parameter int unsigned ROUNDS = 31
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        start,
  input  logic [63:0] plaintext,
  input  logic [79:0] key,
  output logic        busy,
  output logic        done,
  output logic [63:0] ciphertext,
  output logic [4:0]  round_count
);

  // FSM encoding
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRound = 2'd1;
  localparam logic [1:0] StFinal = 2'd2;

  localparam logic [4:0] LastRound = 5'(ROUNDS);

  // ---------------------------------------------------------------------------
  // PRESENT primitives
  // ---------------------------------------------------------------------------

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Sixteen parallel 4-bit S-boxes across the state.
  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) begin
      y[4*n +: 4] = sbox4(x[4*n +: 4]);
    end
    return y;
  endfunction

  // Bit i moves to position 16*i mod 63; bit 63 stays put. Pure wiring.
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) begin
      y[6'((i * 16) % 63)] = x[i];
    end
    y[63] = x[63];
    return y;
  endfunction

  // One step of the 80-bit key schedule for round counter rc.
  function automatic logic [79:0] key_update(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r          = {k[18:0], k[79:19]};  // rotate left by 61
    r[79:76]   = sbox4(r[79:76]);
    r[19:15]   = r[19:15] ^ rc;
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  logic [1:0]  fsm_reg,   fsm_next;
  logic [63:0] state_reg, state_next;
  logic [79:0] key_reg,   key_next;
  logic [63:0] ct_reg,    ct_next;
  logic [4:0]  rc_reg,    rc_next;
  logic        busy_reg,  busy_next;
  logic        done_reg,  done_next;

  // Shared round datapath
  logic [63:0] round_key;
  logic [63:0] round_out;
  logic [79:0] key_sched;
  logic [63:0] whitened;

  // Round datapath and key schedule driven from the current registers.
  always_comb begin
    round_key = key_reg[79:16];
    whitened  = state_reg ^ round_key;
    round_out = p_layer(s_layer(whitened));
    key_sched = key_update(key_reg, rc_reg);
  end

  // Next-state logic; every register holds unless the FSM says otherwise.
  always_comb begin
    fsm_next   = fsm_reg;
    state_next = state_reg;
    key_next   = key_reg;
    ct_next    = ct_reg;
    rc_next    = rc_reg;
    busy_next  = busy_reg;
    done_next  = done_reg;

    case (fsm_reg)
      StIdle: begin
        done_next = 1'b0;
        if (start) begin
          state_next = plaintext;
          key_next   = key;
          rc_next    = 5'd1;
          busy_next  = 1'b1;
          fsm_next   = StRound;
        end
      end

      StRound: begin
        state_next = round_out;
        key_next   = key_sched;
        if (rc_reg == LastRound) begin
          fsm_next = StFinal;
        end else begin
          rc_next = rc_reg + 5'd1;
        end
      end

      StFinal: begin
        // Key register now holds K(ROUNDS+1), the whitening key.
        ct_next   = whitened;
        done_next = 1'b1;
        busy_next = 1'b0;
        rc_next   = 5'd0;
        fsm_next  = StIdle;
      end

      default: begin
        // Unreachable encoding: drop back to a clean idle.
        fsm_next  = StIdle;
        busy_next = 1'b0;
        done_next = 1'b0;
        rc_next   = 5'd0;
      end
    endcase
  end

  // State update on enabled edges; asynchronous clear on reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_reg   <= StIdle;
      state_reg <= '0;
      key_reg   <= '0;
      ct_reg    <= '0;
      rc_reg    <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (enable) begin
      fsm_reg   <= fsm_next;
      state_reg <= state_next;
      key_reg   <= key_next;
      ct_reg    <= ct_next;
      rc_reg    <= rc_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    busy        = busy_reg;
    done        = done_reg;
    ciphertext  = ct_reg;
    round_count = rc_reg;
  end

endmodule

// File: tb/tb_present_round_ctrl.sv
// Self-checking bench for present_round_ctrl with a bit-level PRESENT-80 model.
module tb_present_round_ctrl;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic        start;
  logic [63:0] plaintext;
  logic [79:0] key;
  logic        busy;
  logic        done;
  logic [63:0] ciphertext;
  logic [4:0]  round_count;

  int checks   = 0;
  int failures = 0;
  logic [63:0] last_ct;

  logic [3:0] sbox_tab [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  present_round_ctrl #(.ROUNDS(31)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .start       (start),
    .plaintext   (plaintext),
    .key         (key),
    .busy        (busy),
    .done        (done),
    .ciphertext  (ciphertext),
    .round_count (round_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: state after n rounds, optionally followed by the final whitening.
  function automatic logic [63:0] model(input logic [63:0] pt, input logic [79:0] k0,
                                        input int n, input bit whiten);
    logic [63:0] s;
    logic [63:0] t;
    logic [79:0] k;
    int p;
    s = pt;
    k = k0;
    for (int r = 1; r <= n; r++) begin
      s = s ^ k[79:16];
      for (int j = 0; j < 16; j++) s[4*j +: 4] = sbox_tab[s[4*j +: 4]];
      t = '0;
      for (int b = 0; b < 64; b++) begin
        p = (b == 63) ? 63 : (b * 16) % 63;
        t[p] = s[b];
      end
      s = t;
      k = (k << 61) | (k >> 19);
      k[79:76] = sbox_tab[k[79:76]];
      k[19:15] = k[19:15] ^ 5'(r);
    end
    if (whiten) s = s ^ k[79:16];
    return s;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; start = 1'b0; plaintext = '0; key = '0;
    #12;
    checks++;
    if ({busy, done, ciphertext, round_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b ct=%h rc=%0d, want all 0",
               busy, done, ciphertext, round_count);
    end
    #3 reset_n = 1'b1;
    enable = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || round_count !== 5'd0) begin
      failures++;
      $display("FAIL reset_idle: got busy=%b rc=%0d, want 0/0", busy, round_count);
    end
    last_ct = '0;
  endtask

  // One full encryption with enable high; checks latency, busy width, hold and result.
  task automatic run_one(input logic [63:0] pt, input logic [79:0] k,
                         input logic [63:0] exp_ct, input string tag);
    int n;
    int busy_cnt;
    bit hold_bad;
    plaintext = pt; key = k; start = 1'b1; enable = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || round_count !== 5'd1 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s_accept: got busy=%b rc=%0d done=%b, want 1/1/0",
               tag, busy, round_count, done);
    end
    start = 1'b0;
    n = 0; busy_cnt = 1; hold_bad = 0;
    while (!done && n < 40) begin
      tick();
      n++;
      if (busy) busy_cnt++;
      if (!done && ciphertext !== last_ct) hold_bad = 1;
    end
    checks++;
    if (n !== 32) begin
      failures++;
      $display("FAIL %s_latency: got done after %0d edges, want 32", tag, n);
    end
    checks++;
    if (busy_cnt !== 32) begin
      failures++;
      $display("FAIL %s_busy_width: got %0d cycles, want 32", tag, busy_cnt);
    end
    checks++;
    if (hold_bad) begin
      failures++;
      $display("FAIL %s_ct_hold: ciphertext changed before done, want %h held", tag, last_ct);
    end
    checks++;
    if (ciphertext !== exp_ct || busy !== 1'b0 || round_count !== 5'd0) begin
      failures++;
      $display("FAIL %s_result: got ct=%h busy=%b rc=%0d, want ct=%h busy=0 rc=0",
               tag, ciphertext, busy, round_count, exp_ct);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_pulse: got done=%b one edge later, want 0", tag, done);
    end
    last_ct = exp_ct;
  endtask

  task automatic test_known_vectors();
    run_one(64'h0, 80'h0, 64'h5579C1387B228445, "kv_zero");
    run_one(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, "kv_key1");
    run_one({64{1'b1}}, 80'h0, 64'hA112FFC72F68417B, "kv_pt1");
    run_one({64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2, "kv_all1");
  endtask

  task automatic test_first_rounds();
    logic [63:0] pt;
    logic [79:0] k;
    logic [63:0] exp_s;
    int n;
    pt = {$urandom, $urandom};
    k  = {16'($urandom), $urandom, $urandom};
    plaintext = pt; key = k; start = 1'b1; enable = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 0; e < 5; e++) begin
      if (e > 0) tick();
      exp_s = model(pt, k, e, 1'b0);
      checks++;
      if (round_count !== 5'(e + 1) || dut.state_reg !== exp_s) begin
        failures++;
        $display("FAIL first_rounds_%0d: got rc=%0d state=%h, want rc=%0d state=%h",
                 e, round_count, dut.state_reg, e + 1, exp_s);
      end
    end
    n = 4;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 32 || ciphertext !== model(pt, k, 31, 1'b1)) begin
      failures++;
      $display("FAIL first_rounds_result: got ct=%h after %0d edges, want %h after 32",
               ciphertext, n, model(pt, k, 31, 1'b1));
    end
    last_ct = model(pt, k, 31, 1'b1);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [63:0] vp [4];
    logic [79:0] vk [4];
    logic [63:0] ve [4];
    int n;
    vp = '{64'h0, 64'h0, {64{1'b1}}, {64{1'b1}}};
    vk = '{80'h0, {80{1'b1}}, 80'h0, {80{1'b1}}};
    ve = '{64'h5579C1387B228445, 64'hE72C46C0F5945049,
           64'hA112FFC72F68417B, 64'h3333DCD3213210D2};
    plaintext = vp[0]; key = vk[0]; start = 1'b1; enable = 1'b1;
    tick();
    for (int j = 0; j < 4; j++) begin
      if (j < 3) begin
        plaintext = vp[j+1]; key = vk[j+1];
      end else begin
        start = 1'b0;
      end
      n = 0;
      while (!done && n < 40) begin
        tick();
        n++;
      end
      checks++;
      if (n !== 32 || ciphertext !== ve[j]) begin
        failures++;
        $display("FAIL b2b_%0d: got ct=%h after %0d edges, want %h after 32",
                 j, ciphertext, n, ve[j]);
      end
      if (j < 3) begin
        tick();
        checks++;
        if (busy !== 1'b1 || round_count !== 5'd1 || done !== 1'b0) begin
          failures++;
          $display("FAIL b2b_restart_%0d: got busy=%b rc=%0d done=%b, want 1/1/0",
                   j, busy, round_count, done);
        end
      end
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_stop: got done=%b busy=%b, want 0/0", done, busy);
    end
    last_ct = ve[3];
  endtask

  task automatic test_ignore_start();
    logic [63:0] pt;
    logic [79:0] k;
    logic [63:0] exp_ct;
    bit busy_bad;
    pt = {$urandom, $urandom};
    k  = {16'($urandom), $urandom, $urandom};
    exp_ct = model(pt, k, 31, 1'b1);
    plaintext = pt; key = k; start = 1'b1; enable = 1'b1;
    tick();
    busy_bad = 0;
    for (int n = 1; n <= 31; n++) begin
      start     = 1'($urandom % 2);
      plaintext = {$urandom, $urandom};
      key       = {16'($urandom), $urandom, $urandom};
      tick();
      if (busy !== 1'b1 || done !== 1'b0) busy_bad = 1;
    end
    start = 1'b0;
    tick();
    checks++;
    if (busy_bad) begin
      failures++;
      $display("FAIL ignore_busy: busy/done disturbed by mid-run start, want busy=1 done=0");
    end
    checks++;
    if (done !== 1'b1 || ciphertext !== exp_ct) begin
      failures++;
      $display("FAIL ignore_result: got done=%b ct=%h, want 1 %h", done, ciphertext, exp_ct);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL ignore_no_restart: got busy=%b done=%b, want 0/0", busy, done);
    end
    last_ct = exp_ct;
  endtask

  task automatic test_enable_toggle();
    int k;
    int cyc;
    logic en;
    logic [4:0] exp_rc;
    plaintext = '0; key = '0; start = 1'b1; enable = 1'b1;
    tick();
    start = 1'b0;
    k = 0; cyc = 0;
    while (k < 33 && cyc < 600) begin
      en = (cyc > 400) ? 1'b1 : 1'($urandom % 2);
      enable = en;
      tick();
      cyc++;
      if (en) k++;
      exp_rc = (k <= 30) ? 5'(k + 1) : ((k == 31) ? 5'd31 : 5'd0);
      checks++;
      if (round_count !== exp_rc || done !== (k == 32) || busy !== (k < 32)) begin
        failures++;
        $display("FAIL enable_step_%0d: got rc=%0d done=%b busy=%b, want rc=%0d done=%b busy=%b",
                 k, round_count, done, busy, exp_rc, (k == 32), (k < 32));
      end
      if (k == 32) begin
        checks++;
        if (ciphertext !== 64'h5579C1387B228445) begin
          failures++;
          $display("FAIL enable_result: got %h, want 5579c1387b228445", ciphertext);
        end
      end
    end
    checks++;
    if (k !== 33) begin
      failures++;
      $display("FAIL enable_timeout: got %0d enabled edges, want 33", k);
    end
    enable = 1'b1;
    last_ct = 64'h5579C1387B228445;
  endtask

  task automatic test_async_reset();
    plaintext = {$urandom, $urandom};
    key = {16'($urandom), $urandom, $urandom};
    start = 1'b1; enable = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    checks++;
    if (round_count !== 5'd15) begin
      failures++;
      $display("FAIL areset_pre: got rc=%0d, want 15", round_count);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, ciphertext, round_count} !== '0 || dut.state_reg !== 64'h0
        || dut.key_reg !== 80'h0 || dut.fsm_reg !== 2'd0) begin
      failures++;
      $display("FAIL areset_clear: got busy=%b done=%b ct=%h rc=%0d state=%h, want all 0",
               busy, done, ciphertext, round_count, dut.state_reg);
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL areset_idle: got done=%b busy=%b, want 0/0", done, busy);
    end
    last_ct = '0;
    run_one(64'h0, 80'h0, 64'h5579C1387B228445, "after_reset");
  endtask

  task automatic test_random();
    logic [63:0] pt;
    logic [79:0] k;
    for (int i = 0; i < 3; i++) begin
      pt = {$urandom, $urandom};
      k  = {16'($urandom), $urandom, $urandom};
      run_one(pt, k, model(pt, k, 31, 1'b1), "random");
    end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_first_rounds();
    test_back_to_back();
    test_ignore_start();
    test_enable_toggle();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
